prefetch_fetch: RTL and testbench
=================================

// Module: prefetch_fetch
// PURPOSE
//   Next-generation fetch stage: successor to the single-slot fetch unit, with a parametrised
//   prefetch buffer of DEPTH {pc,instr} entries between imem and decode.
//   Keeps one imem read in flight every cycle while buffer space allows; decode drains via valid/stall.
//   Redirect from EX (branch/jump) flushes the buffer and any in-flight response.
// PARAMETERS
//   DEPTH     4              prefetch entries; power of 2, >=2
//   RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//   clk_i         in   1   clock; all state on rising edge
//   rst_i         in   1   reset, synchronous, active-high
//   valid_o       out  1   instr_o/pc_o hold a valid instruction
//   instr_o       out  32  instruction at buffer head
//   pc_o          out  32  pc of instr_o
//   stall_i       in   1   decode cannot accept; head is held
//   pc_i          in   32  redirect target
//   new_pc_i      in   1   redirect strobe (one cycle)
//   read_o        out  1   imem read request
//   raddr_o       out  32  imem read address, word aligned
//   rdata_i       in   32  imem data, valid exactly 1 cycle after read_o
// BEHAVIOUR
//   Reset (rst_i=1 at edge): valid_o=0, instr_o=0, pc_o=0, read_o=0, raddr_o=RESET_PC,
//     fetch_pc=RESET_PC, count=0, inflight=0, all entries cleared. First read in cycle after reset.
//   Pop: valid_o && !stall_i && !new_pc_i -> head removed at edge.
//   Issue: read_o=1 when (count+inflight < DEPTH) || pop; raddr_o=fetch_pc; fetch_pc += 4.
//     Buffer can never overflow; imem has no backpressure.
//   Response: inflight=1 in cycle t+1 -> {pc,rdata_i} pushed at end of t+1;
//     visible on valid_o at t+2 (2-cycle fetch-to-decode latency).
//   Push and pop same cycle: count unchanged; when count==0, push+pop cannot coincide.
//   Full: count==DEPTH and no pop -> read_o=0, fetch_pc held.
//   Empty: valid_o=0; instr_o/pc_o hold last head value (decode ignores when !valid_o).
//   Redirect (new_pc_i=1): top priority over stall, pop and response.
//     Buffer flushed (count=0), response arriving this cycle dropped.
//     read_o=1 with raddr_o=pc_i this cycle (combinational path); fetch_pc<=pc_i+4; inflight<=1.
//     valid_o=0 next cycle. Head offered during the redirect cycle is void.
//     Downstream flushes ID on the same strobe.
//   Pointers: rd/wr pointers of log2(DEPTH) bits wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//   pc arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 (no trap here).
//   Reset mid-operation: flushes everything; in-flight response on next cycle ignored.
//     inflight is cleared on reset.
// CONFIGURATION
//   FETCH_BYPASS_EN defined:
//     count==0 && inflight && !new_pc_i -> rdata_i/pc driven combinationally on instr_o/pc_o,
//       with valid_o=1 (1-cycle latency).
//     If also !stall_i: entry consumed, not pushed; otherwise pushed as usual.
//   FETCH_BYPASS_EN undefined: outputs always from buffer head (registered path),
//     2-cycle latency as above.
// STRUCTURE
//   Shared package fetch_pkg: fetch_entry_t {logic [31:0] pc; logic [31:0] instr;},
//     INSTR_BYTES=4, NOP=32'h0000_0013.
//   Sub-module sync_fifo #(type T, DEPTH): storage, pointers, count, flush input.
//   prefetch_fetch owns: fetch_pc, inflight, issue credit, redirect, bypass.
// TESTING
//   1. Reset, stall_i=0, imem returns addr as data -> reads 0,4,8 on back-to-back cycles.
//      valid_o first high 2 cycles after first read; instr_o=pc_o each cycle.
//   2. stall_i=1 held 10 cycles, DEPTH=4 -> exactly 4 reads then read_o=0.
//      count=4; head stays pc 0; release -> pcs 0,4,8,12,16 in order, no gaps or dups.
//   3. new_pc_i with pc_i=32'h100 while buffer half full and response in flight
//      -> raddr_o=0x100 same cycle; valid_o=0 next cycle; next valid pc_o=0x100, then 0x104.
//   4. Redirect with stall_i=1 and buffer full -> redirect wins; count=0; no stale pc ever reaches valid_o.
//   5. rst_i asserted mid-stream with inflight=1 -> all outputs at reset values next cycle.
//      Dropped response never pushed; restart at RESET_PC.
//   6. FETCH_BYPASS_EN on, empty buffer -> valid_o high 1 cycle after read_o with pc_o=raddr.
//      Off -> 2 cycles; pc_i=32'hFFFF_FFFC wraps next fetch to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/prefetch_fetch_if.sv
// Decode, redirect and imem signals of the fetch stage.
// master = fetch stage, slave = surrounding pipeline/imem.
interface prefetch_fetch_if;

    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        new_pc_i;
    logic        read_o;
    logic [31:0] raddr_o;
    logic [31:0] rdata_i;

    modport master (
        output valid_o, instr_o, pc_o, read_o, raddr_o,
        input  stall_i, pc_i, new_pc_i, rdata_i
    );

    modport slave (
        input  valid_o, instr_o, pc_o, read_o, raddr_o,
        output stall_i, pc_i, new_pc_i, rdata_i
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
// Callers guarantee no push when full and no pop when empty.
module sync_fifo #(
    parameter type         T     = logic [63:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         push_data_i,
    input  logic                     pop_i,
    output T                         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetch.sv
// Prefetching fetch stage: keeps one imem read in flight and buffers DEPTH {pc,instr} entries.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module prefetch_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    prefetch_fetch_if.master  fif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    fetch_entry_t  last_q, last_d;

    fetch_entry_t  head;
    fetch_entry_t  resp;
    fetch_entry_t  out_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          buf_valid;
    logic          bypass_active;
    logic          valid;
    logic          pop;
    logic          issue;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic [31:0]   raddr;

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (resp),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        resp.pc    = inflight_pc_q;
        resp.instr = fif.rdata_i;
        buf_valid  = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass_active = !buf_valid && inflight_q && !fif.new_pc_i && !rst_i;
`else
        bypass_active = 1'b0;
`endif
        valid = buf_valid || bypass_active;

        // Redirect outranks stall, pop and the arriving response.
        pop        = valid && !fif.stall_i && !fif.new_pc_i;
        fifo_pop   = pop && buf_valid;
        fifo_flush = fif.new_pc_i && !rst_i;
        fifo_push  = inflight_q && !fif.new_pc_i && !rst_i && !(bypass_active && pop);

        // Counting the in-flight read as occupied space is what prevents overflow.
        occupancy = count + {{(CW-1){1'b0}}, inflight_q};
        issue     = !rst_i && (fif.new_pc_i || (occupancy < CW'(DEPTH)) || pop);
        raddr     = (fif.new_pc_i && !rst_i) ? fif.pc_i : fetch_pc_q;

        fetch_pc_d    = issue ? next_pc(raddr) : fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? raddr : inflight_pc_q;

        if (bypass_active) begin
            out_entry = resp;
        end else if (buf_valid) begin
            out_entry = head;
        end else begin
            out_entry = last_q;
        end
        last_d = out_entry;
    end

    always_comb begin
        fif.valid_o = valid;
        fif.instr_o = out_entry.instr;
        fif.pc_o    = out_entry.pc;
        fif.read_o  = issue;
        fif.raddr_o = raddr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            last_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            last_q        <= last_d;
        end
    end

endmodule

// File: tb/tb_prefetch_fetch.sv
// Self-checking bench for prefetch_fetch: imem model plus a scoreboard of expected {pc,instr}.
module tb_prefetch_fetch;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    prefetch_fetch_if fif();

    prefetch_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .fif   (fif)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops   = 0;
    logic [31:0]  key      = 32'h0;
    logic         rd_pending = 1'b0;
    logic [31:0]  rd_addr    = 32'h0;
    fetch_entry_t sb_q[$];

    logic         o_valid, o_read;
    logic [31:0]  o_pc, o_instr, o_raddr;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] start);
        fetch_entry_t e;
        for (int i = 0; i < 32; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_f(e.pc);
            sb_q.push_back(e);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later, score any pop.
    task automatic cyc(input logic rst, input logic stall, input logic npc, input logic [31:0] tgt);
        fetch_entry_t e;
        @(negedge clk_i);
        rst_i        = rst;
        fif.stall_i  = stall;
        fif.new_pc_i = npc;
        fif.pc_i     = tgt;
        fif.rdata_i  = rd_pending ? mem_f(rd_addr) : 32'hBAD0_BAD0;
        #1;
        o_valid = fif.valid_o;
        o_pc    = fif.pc_o;
        o_instr = fif.instr_o;
        o_read  = fif.read_o;
        o_raddr = fif.raddr_o;
        if (!rst && o_valid && !stall && !npc) begin
            n_pops++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("pop_pc", o_pc, e.pc);
                chk("pop_instr", o_instr, e.instr);
            end
        end
        rd_pending = o_read;
        rd_addr    = o_raddr;
        if (rst) begin
            sb_q.delete();
            push_run(RESET_PC);
        end else if (npc) begin
            sb_q.delete();
            push_run(tgt);
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_read", 32'(o_read), 32'd0);
        chk("rst_raddr", o_raddr, RESET_PC);
    endtask

    initial begin
        int first;
        int n_rd;
        int p0;
        fif.stall_i  = 1'b0;
        fif.new_pc_i = 1'b0;
        fif.pc_i     = 32'h0;
        fif.rdata_i  = 32'h0;

        // Streaming from reset, imem returns address as data.
        do_reset();
        first = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (i < 3) begin
                chk("t1_read", 32'(o_read), 32'd1);
                chk("t1_raddr", o_raddr, RESET_PC + 32'(4 * i));
            end
            if (o_valid && first < 0) first = i;
        end
        chk("t1_latency", 32'(first), 32'(LAT));

        // Stall from reset fills the buffer, then drains without gaps.
        key = 32'h5A5A_0000;
        do_reset();
        n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            n_rd += int'(o_read);
        end
        chk("t2_reads", 32'(n_rd), 32'(DEPTH));
        chk("t2_read_off", 32'(o_read), 32'd0);
        chk("t2_head_valid", 32'(o_valid), 32'd1);
        chk("t2_head_pc", o_pc, RESET_PC);
        p0 = n_pops;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_drain_pops", 32'(n_pops - p0), 32'd8);

        // Redirect with buffer half full and a response in flight.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("t3_read", 32'(o_read), 32'd1);
        chk("t3_raddr", o_raddr, 32'h0000_0100);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_valid_after", 32'(o_valid), 32'(LAT == 1));
        p0 = n_pops;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_pops", 32'(n_pops - p0), 32'd6);

        // Redirect while full and stalled.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t4_full_read", 32'(o_read), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        chk("t4_raddr", o_raddr, 32'h0000_0200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t4_valid_after", 32'(o_valid), 32'(LAT == 1));
        p0 = n_pops;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pops", 32'(n_pops - p0), 32'd6);

        // Reset mid-stream with a read in flight, then restart.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        first = -1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 0) chk("t5_restart_raddr", o_raddr, RESET_PC);
            if (o_valid && first < 0) first = i;
        end
        chk("t5_latency", 32'(first), 32'(LAT));

        // Redirect to the top of the address space wraps to 0.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("t6_raddr", o_raddr, 32'hFFFF_FFFC);
        first = -1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 0) chk("t6_wrap_raddr", o_raddr, 32'h0000_0000);
            if (o_valid && first < 0) first = i;
        end
        chk("t6_latency", 32'(first), 32'(LAT - 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
